// File: rtl/decoder_scan_seq.sv
// decoder_scan_seq: drives the 5-bit select and enable of a 5-to-32 decoder.
// It steps through unmasked indices 0..LAST and holds each one for DWELL cycles.
// It runs a single pass or scans continuously.
// Optional feature: define SCAN_GAP_EN to insert one dead cycle (sel_en=0)
// between consecutive dwells, giving break-before-make on the decoder outputs.
module decoder_scan_seq #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned LAST  = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        cont,
  input  logic [31:0] mask,
  output logic [4:0]  sel,
  output logic        sel_en,
  output logic        busy,
  output logic        done,
  output logic        wrap
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DWELL - 1);

`ifdef SCAN_GAP_EN
  typedef enum logic [1:0] {IDLE, DWELL_ST, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, DWELL_ST} state_t;
`endif

  state_t           state_q, state_d;
  logic [4:0]       sel_q, sel_d;
  logic             sel_en_q, sel_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mask_q, mask_d;
  logic             cont_q, cont_d;

  logic [31:0]      srch_mask;
  logic [5:0]       first_idx;
  logic [5:0]       next_idx;
  logic             first_ok;
  logic             next_ok;

  // Lowest unmasked index j >= lo with j <= LAST; bit 5 set means none found.
  function automatic logic [5:0] find_from(input logic [31:0] m, input logic [5:0] lo);
    logic [5:0] r;
    r = 6'd32;
    for (int j = 31; j >= 0; j--) begin
      if ((j <= int'(LAST)) && !m[j] && (6'(j) >= lo)) r = 6'(j);
    end
    return r;
  endfunction

  // Index search: IDLE looks at the live mask (it is latched on the same edge).
  always_comb begin
    srch_mask = (state_q == IDLE) ? mask : mask_q;
    first_idx = find_from(srch_mask, 6'd0);
    next_idx  = find_from(mask_q, {1'b0, sel_q} + 6'd1);
    first_ok  = !first_idx[5];
    next_ok   = !next_idx[5];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    sel_en_d = sel_en_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    wrap_d   = 1'b0;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    cont_d   = cont_q;

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          mask_d = mask;
          cont_d = cont;
          if (first_ok) begin
            state_d  = DWELL_ST;
            sel_d    = first_idx[4:0];
            sel_en_d = 1'b1;
            busy_d   = 1'b1;
            cnt_d    = CNT_INIT;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      DWELL_ST: begin
        if (stop) begin
          state_d  = IDLE;
          sel_en_d = 1'b0;
          busy_d   = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (next_ok || cont_q) begin
          sel_d = next_ok ? next_idx[4:0] : first_idx[4:0];
`ifdef SCAN_GAP_EN
          state_d  = GAP;
          sel_en_d = 1'b0;
`else
          sel_en_d = 1'b1;
          cnt_d    = CNT_INIT;
          wrap_d   = !next_ok;
`endif
        end else begin
          state_d  = IDLE;
          sel_en_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end

`ifdef SCAN_GAP_EN
      GAP: begin
        if (stop) begin
          state_d  = IDLE;
          sel_en_d = 1'b0;
          busy_d   = 1'b0;
        end else begin
          state_d  = DWELL_ST;
          sel_en_d = 1'b1;
          cnt_d    = CNT_INIT;
          // Only a wrap can land in GAP with sel equal to the first index.
          wrap_d   = (sel_q == first_idx[4:0]);
        end
      end
`endif

      default: begin
        state_d  = IDLE;
        sel_en_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers, asynchronously cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      sel_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      cnt_q    <= '0;
      mask_q   <= '0;
      cont_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      sel_en_q <= sel_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wrap_q   <= wrap_d;
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      cont_q   <= cont_d;
    end
  end

  assign sel    = sel_q;
  assign sel_en = sel_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wrap   = wrap_q;

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Scoreboard bench for decoder_scan_seq: the stimulus pushes the expected output
// events, and a negedge monitor pops them and compares them with the DUT outputs.
module tb_decoder_scan_seq;

  localparam int unsigned DWELL = 4;
  localparam int unsigned LAST  = 31;
`ifdef SCAN_GAP_EN
  localparam int GAPC = 1;
`else
  localparam int GAPC = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        cont = 1'b0;
  logic [31:0] mask = '0;
  logic [4:0]  sel;
  logic        sel_en, busy, done, wrap;

  always #5 clk = ~clk;

  decoder_scan_seq #(.DWELL(DWELL), .LAST(LAST)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .mask(mask),
    .sel(sel), .sel_en(sel_en), .busy(busy), .done(done), .wrap(wrap)
  );

  // One expected output event; idle = quiet cycles since the previous event (FF = don't care).
  typedef struct packed {
    logic [4:0] sel;
    logic       chk_sel;
    logic       sel_en;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [7:0] idle;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   idle_cnt = 0;

  // Monitor: each cycle with sel_en, done or wrap high is an event to be scored.
  always @(negedge clk) begin : mon
    exp_t e;
    logic bad;
    if (rst) begin
      idle_cnt = 0;
    end else if (sel_en || done || wrap) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual sel=%0d en=%b busy=%b done=%b wrap=%b required no event",
                 sel, sel_en, busy, done, wrap);
      end else begin
        e = q.pop_front();
        bad = (sel_en !== e.sel_en) || (busy !== e.busy) || (done !== e.done) ||
              (wrap !== e.wrap) || (e.chk_sel && (sel !== e.sel)) ||
              ((e.idle != 8'hFF) && (idle_cnt != int'(e.idle)));
        if (bad) begin
          errors++;
          $display("FAIL scoreboard actual sel=%0d en=%b busy=%b done=%b wrap=%b idle=%0d required sel=%0d en=%b busy=%b done=%b wrap=%b idle=%0d",
                   sel, sel_en, busy, done, wrap, idle_cnt,
                   e.sel, e.sel_en, e.busy, e.done, e.wrap, e.idle);
        end
      end
      idle_cnt = 0;
    end else begin
      idle_cnt++;
    end
  end

  // Expected event list for a scan of `passes` passes; limit >= 0 truncates the dwell entries.
  task automatic push_scan(input logic [31:0] m, input int passes, input bit fin, input int limit);
    int   lst[$];
    int   n;
    exp_t e;
    n = 0;
    for (int j = 0; j <= int'(LAST); j++) if (!m[j]) lst.push_back(j);
    if (lst.size() == 0) begin
      if (fin) begin
        e = '0; e.done = 1'b1; e.idle = 8'hFF;
        q.push_back(e);
      end
      return;
    end
    for (int p = 0; p < passes; p++)
      for (int k = 0; k < lst.size(); k++)
        for (int d = 0; d < int'(DWELL); d++) begin
          if (limit >= 0 && n >= limit) return;
          e = '0;
          e.sel = 5'(lst[k]); e.chk_sel = 1'b1; e.sel_en = 1'b1; e.busy = 1'b1;
          e.wrap = (p > 0 && k == 0 && d == 0);
          e.idle = (d > 0) ? 8'd0 : ((p == 0 && k == 0) ? 8'hFF : 8'(GAPC));
          q.push_back(e);
          n++;
        end
    if (fin) begin
      e = '0;
      e.sel = 5'(lst[lst.size()-1]); e.chk_sel = 1'b1; e.done = 1'b1; e.idle = 8'd0;
      q.push_back(e);
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] m, input logic c);
    @(posedge clk); #1;
    mask = m; cont = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cont = ~c; mask = ~m;
  endtask

  task automatic drain(input int maxc, input string name);
    int c;
    c = 0;
    while (q.size() != 0 && c < maxc) begin
      @(negedge clk); #1;
      c++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s actual=%0d left required=0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_sel", 32'(sel), 0);
    check("rst_sel_en", 32'(sel_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wrap", 32'(wrap), 0);
    @(negedge clk); rst = 1'b0;

    // Full single pass over all 32 indices
    push_scan(32'h0, 1, 1'b1, -1);
    do_start(32'h0, 1'b0);
    drain(400, "t1");
    tick(4);
    check("t1_busy_after", 32'(busy), 0);

    // Masked pass; a start while busy must be ignored
    push_scan(32'hFFFF_FF0F, 1, 1'b1, -1);
    do_start(32'hFFFF_FF0F, 1'b0);
    tick(3);
    mask = 32'h0; cont = 1'b1; start = 1'b1;
    tick(1);
    start = 1'b0;
    drain(100, "t2");
    tick(4);

    // Everything masked: immediate done, never busy
    push_scan(32'hFFFF_FFFF, 1, 1'b1, -1);
    do_start(32'hFFFF_FFFF, 1'b0);
    check("t3_done", 32'(done), 1);
    check("t3_busy", 32'(busy), 0);
    drain(10, "t3");
    tick(3);

    // Continuous 0,1 scan with wraps, stopped during sel=1
    push_scan(32'hFFFF_FFFC, 3, 1'b0, 2 * 2 * int'(DWELL) + int'(DWELL) + 2);
    do_start(32'hFFFF_FFFC, 1'b1);
    drain(200, "t4");
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    check("t4_sel_en", 32'(sel_en), 0);
    check("t4_busy", 32'(busy), 0);
    check("t4_done", 32'(done), 0);
    check("t4_sel_held", 32'(sel), 1);
    tick(10);

    // Asynchronous reset in the middle of the dwell on index 10
    push_scan(32'h0, 1, 1'b0, 10 * int'(DWELL) + 2);
    do_start(32'h0, 1'b0);
    drain(300, "t5");
    #1 rst = 1'b1;
    #1;
    check("t5_sel", 32'(sel), 0);
    check("t5_sel_en", 32'(sel_en), 0);
    check("t5_busy", 32'(busy), 0);
    check("t5_done", 32'(done), 0);
    check("t5_wrap", 32'(wrap), 0);
    q.delete();
    #1 rst = 1'b0;
    push_scan(32'hFFFF_FFF0, 1, 1'b1, -1);
    do_start(32'hFFFF_FFF0, 1'b0);
    drain(100, "t5b");
    tick(4);

    // start and stop together in IDLE are ignored
    @(posedge clk); #1;
    mask = 32'h0; start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    check("t6_busy", 32'(busy), 0);
    check("t6_sel_en", 32'(sel_en), 0);
    check("t6_done", 32'(done), 0);
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
